// File: rtl/xor_arb_pkg.sv
// Shared types and helpers for the two-requester XOR arbiter.
// Holds the FSM state encoding, requester ids and the round-robin pick function.
package xor_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic REQ0_ID = 1'b0;
  localparam logic REQ1_ID = 1'b1;

  // On a tie the requester that did not own the last completed response wins.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last_grant);
    logic pick;
    if (v0 && v1) begin
      pick = ~last_grant;
    end else if (v1) begin
      pick = REQ1_ID;
    end else begin
      pick = REQ0_ID;
    end
    return pick;
  endfunction

endpackage

// File: rtl/xor_share_arbiter_xor.sv
// Shared bitwise XOR datapath; purely combinational, no carry or flags.
// Fed from the arbiter's captured operand registers.
module bitwise_XOR #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_a ^ i_b;

endmodule

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter sharing one XOR unit between two requesters, with
// operand capture and a registered, id-tagged valid/ready response.
//
// state | meaning
// IDLE  | waiting for a request; grants one requester and captures its operands
// EXEC  | captured operands through the XOR unit; result registered
// RESP  | rsp_valid high, held until the consumer accepts
module xor_share_arbiter
  import xor_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_op_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_id;
  logic [WIDTH-1:0] w_xor;
  logic             w_grant_id;
  logic             w_accept;

  bitwise_XOR #(
    .WIDTH(WIDTH)
  ) u_xor (
    .i_a(r_op_a),
    .i_b(r_op_b),
    .o_y(w_xor)
  );

  assign w_grant_id = rr_pick(req0_valid, req1_valid, r_last_grant);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Readies are gated by rst so nothing is handed over during reset.
        if ((req0_valid || req1_valid) && !rst) begin
          w_accept    = 1'b1;
          req0_ready  = (w_grant_id == REQ0_ID);
          req1_ready  = (w_grant_id == REQ1_ID);
          w_state_nxt = EXEC;
        end
      end
      EXEC: w_state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= REQ1_ID;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_id      <= REQ0_ID;
      r_rsp_data   <= '0;
      r_rsp_id     <= REQ0_ID;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op_a  <= (w_grant_id == REQ1_ID) ? req1_a : req0_a;
        r_op_b  <= (w_grant_id == REQ1_ID) ? req1_b : req0_b;
        r_op_id <= w_grant_id;
      end
      if (r_state == EXEC) begin
        r_rsp_data <= w_xor;
        r_rsp_id   <= r_op_id;
      end
      if ((r_state == RESP) && rsp_ready) begin
        r_last_grant <= r_rsp_id;
      end
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

endmodule
